attenuation_dac_sequencer: RTL and testbench
============================================

ATTENUATION_DAC_SEQUENCER -- requirements
Module: attenuation_dac_sequencer

Interface
REQ-001 Parameter CLK_HALF, default 4: system clocks per half-period of clkdac and per setup/strobe/hold phase; legal range 1..255.
REQ-002 Parameter RESET_A, default 8'hFF: value loaded into both A slots at reset (same-side full gain).
REQ-003 Parameter RESET_B, default 8'h00: value loaded into both B slots at reset (cross-feed off).
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  reset; synchronous and active-low.
REQ-006 wr_en  in  1  single-cycle write strobe for one attenuation slot.
REQ-007 wr_right  in  1  0 = left DAC (csdac1n), 1 = right DAC (csdac2n).
REQ-008 wr_sel_a  in  1  1 = input A of the selected DAC, 0 = input B.
REQ-009 wr_value  in  8  attenuation code to program.
REQ-010 datadac  out  1  serial data / A-B select toward the attenuation block.
REQ-011 clkdac  out  1  shift clock; data sampled on its rising edge.
REQ-012 csdac1n  out  1  left DAC latch strobe, active-low.
REQ-013 csdac2n  out  1  right DAC latch strobe, active-low.
REQ-014 busy  out  1  high while a slot transfer is in progress.
REQ-015 pending  out  4  dirty flag per slot: [0]=LA, [1]=LB, [2]=RA, [3]=RB.

Function
REQ-016 The block SHALL hold four 8-bit shadow registers (LA, LB, RA, RB) plus one dirty bit each; slot index = {wr_right, ~wr_sel_a}.
REQ-017 wr_en SHALL be accepted every cycle with no backpressure: shadow[slot] <= wr_value and dirty[slot] <= 1 on the next edge; repeated writes before transmission coalesce (last value wins).
REQ-018 FSM states: IDLE, SHIFT_LO, SHIFT_HI, SETUP, STROBE, HOLD; every non-IDLE state lasts exactly CLK_HALF cycles, timed by one down-counter.
REQ-019 IDLE: if any dirty bit set, choose slot by round-robin starting at (last_served+1) mod 4, capture shadow value into an 8-bit shift register, clear that dirty bit, set bit counter to 7, go SHIFT_LO; else stay IDLE.
REQ-020 A write to the slot being captured in the same cycle SHALL win: dirty stays 1 and the new value is sent in a later transfer; a write during any transfer sets dirty again for the same reason.
REQ-021 SHIFT_LO: clkdac=0, datadac=captured bit[bit counter] (MSB first); then SHIFT_HI.
REQ-022 SHIFT_HI: clkdac=1, datadac unchanged; on exit, decrement bit counter and go SHIFT_LO, or go SETUP after bit 0.
REQ-023 SETUP: clkdac=0, datadac=1 for A slot / 0 for B slot; then STROBE.
REQ-024 STROBE: the selected csdacNn=0, other strobe 1, datadac held; then HOLD.
REQ-025 HOLD: both strobes 1, datadac held, clkdac 0; on exit record last_served and return to IDLE.
REQ-026 One complete transfer SHALL take exactly 19*CLK_HALF cycles from leaving IDLE to re-entering IDLE (76 at default); IDLE lasts at least one cycle between transfers.
REQ-027 clkdac SHALL never toggle while either strobe is low; both strobes SHALL never be low simultaneously.
REQ-028 All outputs SHALL be registered (glitch-free toward the downstream edge detectors).
REQ-029 busy SHALL be 1 in every state except IDLE; pending SHALL reflect dirty bits directly.

Reset
REQ-030 While reset_n=0 at an edge: state=IDLE, datadac=0, clkdac=0, csdac1n=1, csdac2n=1, busy=0, LA=RA=RESET_A, LB=RB=RESET_B, dirty=4'b1111, last_served=3 (so LA transmits first).
REQ-031 Reset asserted mid-transfer SHALL abort immediately with REQ-030 values; no partial strobe may follow.

Verification
REQ-032 Release reset, no writes -> four transfers in order LA, LB, RA, RB; downstream factors become FF,00,FF,00; pending reaches 0 after 4*(76+1) cycles at defaults.
REQ-033 After idle, write right/A=8'hA5 -> clkdac rising edges carry 1,0,1,0,0,1,0,1; datadac=1 at csdac2n fall; csdac1n stays high.
REQ-034 Write left/B=8'h10 then left/B=8'h20 two cycles later while idle-busy with another slot -> only 8'h20 transmitted for LB, single csdac1n pulse.
REQ-035 Write LA=8'h40 in the cycle its transfer starts, then 8'h80 mid-transfer -> LA sent twice, final downstream value 8'h80.
REQ-036 Set all four dirty simultaneously with last_served=1 -> service order RA, RB, LA, LB.
REQ-037 Assert reset_n=0 during STROBE -> strobe returns high next edge, outputs per REQ-030, full reset sequence repeats.

Source files
------------

// File: rtl/attenuation_dac_sequencer.sv
// Serialises four shadowed 8-bit attenuation codes (LA, LB, RA, RB) onto the
// datadac/clkdac/csdacNn bus, one slot per transfer, round-robin over dirty slots.
module attenuation_dac_sequencer #(
  parameter int unsigned CLK_HALF = 4,
  parameter logic [7:0]  RESET_A  = 8'hFF,
  parameter logic [7:0]  RESET_B  = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       wr_right,
  input  logic       wr_sel_a,
  input  logic [7:0] wr_value,
  output logic       datadac,
  output logic       clkdac,
  output logic       csdac1n,
  output logic       csdac2n,
  output logic       busy,
  output logic [3:0] pending
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  localparam logic [7:0] HALF_M1 = 8'(CLK_HALF - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [1:0] slot_q, slot_d;
  logic [1:0] last_q, last_d;
  logic [3:0] dirty_q, dirty_d;
  logic [7:0] shadow_q [4];
  logic [7:0] shadow_d [4];

  logic datadac_q, datadac_d;
  logic clkdac_q, clkdac_d;
  logic cs1n_q, cs1n_d;
  logic cs2n_q, cs2n_d;
  logic busy_q, busy_d;

  logic [1:0] wslot;
  logic [1:0] sel;
  logic       phase_done;

  // First dirty slot found when searching upward from the one after last.
  function automatic logic [1:0] pick_slot(input logic [3:0] dirty,
                                           input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (dirty[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    slot_d    = slot_q;
    last_d    = last_q;
    dirty_d   = dirty_q;
    shadow_d  = shadow_q;
    datadac_d = datadac_q;
    wslot      = {wr_right, ~wr_sel_a};
    sel        = pick_slot(dirty_q, last_q);
    phase_done = (cnt_q == 8'd0);

    if (state_q == S_IDLE) begin
      if (|dirty_q) begin
        slot_d         = sel;
        shreg_d        = shadow_q[sel];
        dirty_d[sel]   = 1'b0;
        bit_d          = 3'd7;
        cnt_d          = HALF_M1;
        state_d        = S_SHIFT_LO;
      end
    end else if (!phase_done) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = HALF_M1;
      case (state_q)
        S_SHIFT_LO: state_d = S_SHIFT_HI;
        S_SHIFT_HI: begin
          if (bit_q == 3'd0) begin
            state_d = S_SETUP;
          end else begin
            bit_d   = bit_q - 3'd1;
            state_d = S_SHIFT_LO;
          end
        end
        S_SETUP:  state_d = S_STROBE;
        S_STROBE: state_d = S_HOLD;
        S_HOLD: begin
          last_d  = slot_q;
          state_d = S_IDLE;
        end
        default:  state_d = S_IDLE;
      endcase
    end

    // Applied after the capture so a same-cycle write re-marks the slot dirty.
    if (wr_en) begin
      shadow_d[wslot] = wr_value;
      dirty_d[wslot]  = 1'b1;
    end

    clkdac_d = (state_d == S_SHIFT_HI);
    cs1n_d   = !((state_d == S_STROBE) && !slot_d[1]);
    cs2n_d   = !((state_d == S_STROBE) && slot_d[1]);
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_SHIFT_LO: datadac_d = shreg_d[bit_d];
      S_SETUP:    datadac_d = ~slot_d[0];
      default:    datadac_d = datadac_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 3'd0;
      slot_q    <= 2'd0;
      last_q    <= 2'd3;
      dirty_q   <= 4'b1111;
      datadac_q <= 1'b0;
      clkdac_q  <= 1'b0;
      cs1n_q    <= 1'b1;
      cs2n_q    <= 1'b1;
      busy_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= (i[0]) ? RESET_B : RESET_A;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      slot_q    <= slot_d;
      last_q    <= last_d;
      dirty_q   <= dirty_d;
      datadac_q <= datadac_d;
      clkdac_q  <= clkdac_d;
      cs1n_q    <= cs1n_d;
      cs2n_q    <= cs2n_d;
      busy_q    <= busy_d;
      shadow_q  <= shadow_d;
    end
  end

  // Shift data needs no reset: it is always loaded before it is driven out.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign datadac = datadac_q;
  assign clkdac  = clkdac_q;
  assign csdac1n = cs1n_q;
  assign csdac2n = cs2n_q;
  assign busy    = busy_q;
  assign pending = dirty_q;

endmodule

// File: tb/tb_attenuation_dac_sequencer.sv
// Directed bench: a bus monitor rebuilds each strobed transfer from the serial
// pins and the sequences compare those transfers against hand-computed values.
module tb_attenuation_dac_sequencer;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       wr_right;
  logic       wr_sel_a;
  logic [7:0] wr_value;
  logic       datadac;
  logic       clkdac;
  logic       csdac1n;
  logic       csdac2n;
  logic       busy;
  logic [3:0] pending;

  attenuation_dac_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_right (wr_right),
    .wr_sel_a (wr_sel_a),
    .wr_value (wr_value),
    .datadac  (datadac),
    .clkdac   (clkdac),
    .csdac1n  (csdac1n),
    .csdac2n  (csdac2n),
    .busy     (busy),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       right;
    logic       a;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    logic       right;
    logic       sel_a;
    logic [7:0] value;
    ev_t        exp_ev;
  } vec_t;

  ev_t        ev_q [$];
  logic [7:0] dn [4];
  int         last_busy_len = 0;
  int         last_idle_len = 0;
  int         viol_both_low = 0;
  int         viol_clk_strobe = 0;
  int         checks = 0;
  int         failures = 0;

  function automatic ev_t mk(input logic r, input logic a, input logic [7:0] v);
    ev_t e;
    e.right = r;
    e.a     = a;
    e.val   = v;
    return e;
  endfunction

  // Bus monitor: models the downstream shift register and latch.
  initial begin
    logic [7:0] sh;
    logic p_clk, p_cs1, p_cs2, p_busy;
    int busy_run, idle_run;
    ev_t e;
    sh = 8'h00; p_clk = 1'b0; p_cs1 = 1'b1; p_cs2 = 1'b1; p_busy = 1'b0;
    busy_run = 0; idle_run = 0;
    for (int i = 0; i < 4; i++) dn[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!p_clk && clkdac) sh = {sh[6:0], datadac};
      if ((p_cs1 && !csdac1n) || (p_cs2 && !csdac2n)) begin
        e = mk(!csdac2n, datadac, sh);
        ev_q.push_back(e);
        dn[{e.right, ~e.a}] = sh;
      end
      if (!csdac1n && !csdac2n) viol_both_low++;
      if ((clkdac != p_clk) && (!csdac1n || !csdac2n || !p_cs1 || !p_cs2))
        viol_clk_strobe++;
      if (busy) begin
        if (!p_busy) begin
          last_idle_len = idle_run;
          busy_run = 0;
        end
        busy_run++;
      end else begin
        if (p_busy) begin
          last_busy_len = busy_run;
          idle_run = 0;
        end
        idle_run++;
      end
      p_clk = clkdac; p_cs1 = csdac1n; p_cs2 = csdac2n; p_busy = busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get_ev(input string name, output ev_t e, input int budget);
    int n = 0;
    while (ev_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ev_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no strobe within %0d cycles, expected one", name, budget);
      e = '0;
    end else begin
      e = ev_q.pop_front();
    end
  endtask

  task automatic wait_busy(input string name, input logic level, input int budget);
    int n = 0;
    while (busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== level) begin
      checks++;
      failures++;
      $display("FAIL %s: busy=%b after %0d cycles, expected %b", name, busy, budget, level);
    end
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || pending !== 4'h0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0 || pending !== 4'h0) begin
      checks++;
      failures++;
      $display("FAIL %s: busy=%b pending=%h after %0d cycles, expected 0/0",
               name, busy, pending, budget);
    end
  endtask

  task automatic write_slot(input logic r, input logic a, input logic [7:0] v);
    wr_right = r; wr_sel_a = a; wr_value = v; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_clkdac"}, clkdac, 1'b0);
    chk({tag, "_datadac"}, datadac, 1'b0);
    chk({tag, "_cs1n"}, csdac1n, 1'b1);
    chk({tag, "_cs2n"}, csdac2n, 1'b1);
    chk({tag, "_pending"}, pending, 4'hF);
  endtask

  task automatic check_reset_sequence(input string tag);
    ev_t e;
    ev_t exp_rst [4];
    exp_rst[0] = mk(1'b0, 1'b1, 8'hFF);
    exp_rst[1] = mk(1'b0, 1'b0, 8'h00);
    exp_rst[2] = mk(1'b1, 1'b1, 8'hFF);
    exp_rst[3] = mk(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      get_ev($sformatf("%s_ev%0d", tag, i), e, 200);
      chk($sformatf("%s_ev%0d", tag, i), e, exp_rst[i]);
    end
    wait_quiet({tag, "_quiet"}, 200);
    chk({tag, "_busy_len"}, last_busy_len, 76);
    chk({tag, "_idle_gap"}, last_idle_len, 1);
    chk({tag, "_downstream"}, {dn[0], dn[1], dn[2], dn[3]}, 32'hFF00FF00);
  endtask

  initial begin
    vec_t vecs [6];
    logic [7:0] exp_dn [4];
    ev_t e;
    int n;

    vecs[0] = '{1'b1, 1'b1, 8'hA5, mk(1'b1, 1'b1, 8'hA5)};
    vecs[1] = '{1'b0, 1'b0, 8'h3C, mk(1'b0, 1'b0, 8'h3C)};
    vecs[2] = '{1'b0, 1'b1, 8'h81, mk(1'b0, 1'b1, 8'h81)};
    vecs[3] = '{1'b1, 1'b0, 8'h7E, mk(1'b1, 1'b0, 8'h7E)};
    vecs[4] = '{1'b1, 1'b1, 8'h00, mk(1'b1, 1'b1, 8'h00)};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, mk(1'b0, 1'b0, 8'hFF)};

    reset_n = 1'b0; wr_en = 1'b0; wr_right = 1'b0; wr_sel_a = 1'b0; wr_value = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Power-up: reset values go out LA, LB, RA, RB.
    check_reset_sequence("powerup");

    // Single writes from idle.
    exp_dn[0] = 8'hFF; exp_dn[1] = 8'h00; exp_dn[2] = 8'hFF; exp_dn[3] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      write_slot(vecs[i].right, vecs[i].sel_a, vecs[i].value);
      get_ev($sformatf("vec%0d", i), e, 200);
      chk($sformatf("vec%0d", i), e, vecs[i].exp_ev);
      wait_quiet($sformatf("vec%0d_quiet", i), 200);
      exp_dn[{vecs[i].right, ~vecs[i].sel_a}] = vecs[i].value;
    end
    chk("vec_downstream", {dn[0], dn[1], dn[2], dn[3]},
        {exp_dn[0], exp_dn[1], exp_dn[2], exp_dn[3]});

    // Coalescing: two LB writes during an RA transfer send only the last.
    write_slot(1'b1, 1'b1, 8'h11);
    wait_busy("coal_start", 1'b1, 20);
    write_slot(1'b0, 1'b0, 8'h10);
    @(negedge clk);
    write_slot(1'b0, 1'b0, 8'h20);
    get_ev("coal_ra", e, 200);
    chk("coal_ra", e, mk(1'b1, 1'b1, 8'h11));
    get_ev("coal_lb", e, 200);
    chk("coal_lb", e, mk(1'b0, 1'b0, 8'h20));
    wait_quiet("coal_quiet", 200);
    chk("coal_extra_strobes", ev_q.size(), 0);

    // Write landing on the capture cycle is resent; later mid-transfer write wins.
    wr_right = 1'b0; wr_sel_a = 1'b1; wr_value = 8'h55; wr_en = 1'b1;
    @(negedge clk);
    wr_value = 8'h40;
    @(negedge clk);
    wr_en = 1'b0;
    get_ev("cap_first", e, 200);
    chk("cap_first", e, mk(1'b0, 1'b1, 8'h55));
    wait_busy("cap_gap", 1'b0, 40);
    wait_busy("cap_second_start", 1'b1, 5);
    repeat (10) @(negedge clk);
    write_slot(1'b0, 1'b1, 8'h80);
    get_ev("cap_second", e, 200);
    chk("cap_second", e, mk(1'b0, 1'b1, 8'h40));
    get_ev("cap_third", e, 200);
    chk("cap_third", e, mk(1'b0, 1'b1, 8'h80));
    wait_quiet("cap_quiet", 200);
    chk("cap_extra_strobes", ev_q.size(), 0);
    chk("cap_downstream_la", dn[0], 8'h80);

    // Round robin after LB served with every slot dirty: RA, RB, LA, LB.
    write_slot(1'b0, 1'b0, 8'h22);
    wait_busy("rr_start", 1'b1, 20);
    write_slot(1'b0, 1'b1, 8'h33);
    write_slot(1'b1, 1'b1, 8'h31);
    write_slot(1'b1, 1'b0, 8'h32);
    write_slot(1'b0, 1'b0, 8'h34);
    chk("rr_pending_all", pending, 4'hF);
    get_ev("rr_lb0", e, 200);
    chk("rr_lb0", e, mk(1'b0, 1'b0, 8'h22));
    get_ev("rr_ra", e, 200);
    chk("rr_ra", e, mk(1'b1, 1'b1, 8'h31));
    get_ev("rr_rb", e, 200);
    chk("rr_rb", e, mk(1'b1, 1'b0, 8'h32));
    get_ev("rr_la", e, 200);
    chk("rr_la", e, mk(1'b0, 1'b1, 8'h33));
    get_ev("rr_lb1", e, 200);
    chk("rr_lb1", e, mk(1'b0, 1'b0, 8'h34));
    wait_quiet("rr_quiet", 200);

    // Reset during the RB strobe aborts and restarts the power-up sequence.
    write_slot(1'b1, 1'b0, 8'h99);
    n = 0;
    while (csdac2n !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", csdac2n, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    ev_q.delete();
    reset_n = 1'b1;
    check_reset_sequence("rerun");

    chk("both_strobes_low", viol_both_low, 0);
    chk("clk_under_strobe", viol_clk_strobe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
